// File: rtl/mem_access_unit_pkg.sv
// Shared processor-wide definitions for the memory stage: opcodes, FSM
// state encoding and the byte-enable helper.
package mem_access_unit_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return op inside {OP_LW, OP_SW, OP_LBU, OP_SB};
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    // Word accesses are the only ones with an alignment requirement.
    function automatic logic is_word_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Byte stores touch one lane; every other access moves the full word.
    function automatic logic [3:0] be_for(input logic [5:0] opcode, input logic [1:0] addr_lo);
        if (opcode == OP_SB) begin
            return 4'b0001 << addr_lo;
        end
        return 4'b1111;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: LBU selects the addressed byte lane of the read word
// and zero-extends it; LW passes the word through unchanged.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    // Lane select and zero-extension for byte loads.
    always_comb begin
        // NOTE: default assignment first so no path leaves data unassigned, which would infer a latch.
        data = rdata;
        if (opcode == OP_LBU) begin
            data = {24'b0, rdata[{addr_lo, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one LW/SW/LBU/SB access at a time on
// a req/ready port, stalls upstream while it is in flight, and produces a
// registered write-back slot with misalignment and timeout error pulses.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [5:0]  in_opcode,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_misalign,
    output logic        err_timeout
);

    state_e              state_q;
    logic [5:0]          op_q;
    logic [1:0]          addr_lo_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_d;
    logic                timeout_hit;
    logic                in_misaligned;
    logic [31:0]         load_data;

    logic                mem_req_q;
    logic                mem_we_q;
    logic [31:0]         mem_addr_q;
    logic [3:0]          mem_be_q;
    logic [31:0]         mem_wdata_q;
    logic                wb_valid_q;
    logic                wb_we_q;
    logic [4:0]          wb_rd_q;
    logic [31:0]         wb_data_q;
    logic                err_misalign_q;
    logic                err_timeout_q;

    assign wait_cnt_d    = wait_cnt_q + WAIT_W'(1);
    assign timeout_hit   = (wait_cnt_d == WAIT_W'(MAX_WAIT));
    assign in_misaligned = is_word_op(in_opcode) && (in_alu_result[1:0] != 2'b00);

    mem_access_unit_load_align u_load_align (
        .rdata   (mem_rdata),
        .opcode  (op_q),
        .addr_lo (addr_lo_q),
        .data    (load_data)
    );

    // Access FSM with registered memory-port and write-back outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: datapath registers are reset as well so every output reads 0 while in reset.
            state_q        <= ST_IDLE;
            op_q           <= '0;
            addr_lo_q      <= '0;
            wait_cnt_q     <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= '0;
            mem_wdata_q    <= '0;
            wb_valid_q     <= 1'b0;
            wb_we_q        <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            wb_valid_q     <= 1'b0;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    wb_we_q <= 1'b0;
                    if (in_valid) begin
                        wb_rd_q <= in_rd;
                        if (!is_mem_op(in_opcode)) begin
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= 1'b1;
                            wb_data_q  <= in_alu_result;
                        end else if (in_misaligned) begin
                            wb_valid_q     <= 1'b1;
                            wb_data_q      <= '0;
                            err_misalign_q <= 1'b1;
                        end else begin
                            op_q        <= in_opcode;
                            addr_lo_q   <= in_alu_result[1:0];
                            wait_cnt_q  <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store_op(in_opcode);
                            mem_addr_q  <= {in_alu_result[31:2], 2'b00};
                            mem_be_q    <= be_for(in_opcode, in_alu_result[1:0]);
                            mem_wdata_q <= (in_opcode == OP_SB) ? {4{in_store_data[7:0]}}
                                                                : in_store_data;
                            state_q     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    // A response in the final allowed cycle still counts as success.
                    if (mem_ready) begin
                        mem_req_q  <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= !mem_we_q;
                        wb_data_q  <= mem_we_q ? 32'd0 : load_data;
                        state_q    <= ST_DONE;
                    end else if (timeout_hit) begin
                        mem_req_q     <= 1'b0;
                        wb_valid_q    <= 1'b1;
                        wb_we_q       <= 1'b0;
                        wb_data_q     <= '0;
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                ST_DONE: begin
                    wb_we_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall        = (state_q != ST_IDLE);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign err_misalign = err_misalign_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized instructions checked cycle by cycle against a transaction model.
module tb_mem_access_unit;

    localparam int MAX_WAIT = 16;

    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] LBU   = 6'b100100;
    localparam logic [5:0] SB    = 6'b101000;
    localparam logic [5:0] ADDIU = 6'b001001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [5:0]  in_opcode = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_store_data = '0;
    logic [4:0]  in_rd = '0;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_misalign;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_opcode     (in_opcode),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .in_rd         (in_rd),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .err_misalign  (err_misalign),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Presents one instruction in the current (idle) cycle and follows it to
    // completion. k = cycle of mem_req in which the memory answers; k > MAX_WAIT
    // means it never answers. rdv = word returned by memory for loads.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd,
                          input int k, input logic [31:0] rdv);
        bit          is_load, is_store, is_mem, mis, tmo;
        logic [31:0] exp_be, exp_wd, exp_data;
        is_load  = (op == LW) || (op == LBU);
        is_store = (op == SW) || (op == SB);
        is_mem   = is_load || is_store;
        mis      = ((op == LW) || (op == SW)) && ((addr % 4) != 0);
        tmo      = (k > MAX_WAIT);

        check("accept_stall", 32'(stall), 32'd0);
        in_valid      = 1'b1;
        in_opcode     = op;
        in_alu_result = addr;
        in_store_data = sdata;
        in_rd         = rd;
        mem_ready     = 1'($urandom_range(0, 1));
        mem_rdata     = $urandom;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        mem_ready = 1'b0;

        if (!is_mem || mis) begin
            check("wb_valid", 32'(wb_valid), 32'd1);
            check("wb_we", 32'(wb_we), 32'(!is_mem));
            check("wb_rd", 32'(wb_rd), 32'(rd));
            if (!is_mem) check("wb_data_alu", wb_data, addr);
            check("err_misalign", 32'(err_misalign), 32'(mis));
            check("err_timeout_quiet", 32'(err_timeout), 32'd0);
            check("no_stall", 32'(stall), 32'd0);
            check("no_mem_req", 32'(mem_req), 32'd0);
            return;
        end

        exp_be = (op == SB) ? (32'd1 << (addr % 4)) : 32'd15;
        exp_wd = (op == SB) ? (sdata & 32'hFF) * 32'h0101_0101 : sdata;

        for (int c = 1; c <= MAX_WAIT; c++) begin
            check("acc_mem_req", 32'(mem_req), 32'd1);
            check("acc_stall", 32'(stall), 32'd1);
            check("acc_wb_valid", 32'(wb_valid), 32'd0);
            check("acc_mem_addr", mem_addr, addr - (addr % 4));
            check("acc_mem_be", 32'(mem_be), exp_be);
            check("acc_mem_we", 32'(mem_we), 32'(is_store));
            if (is_store) check("acc_mem_wdata", mem_wdata, exp_wd);
            mem_ready     = (c == k);
            mem_rdata     = (c == k) ? rdv : $urandom;
            in_valid      = 1'($urandom_range(0, 1));
            in_opcode     = ADDIU;
            in_alu_result = $urandom;
            in_rd         = 5'($urandom);
            @(posedge clk); #1;
            if (c == k) break;
        end
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;

        exp_data = (op == LW) ? rdv : ((rdv >> (8 * (addr % 4))) & 32'hFF);
        check("done_wb_valid", 32'(wb_valid), 32'd1);
        check("done_wb_we", 32'(wb_we), 32'(is_load && !tmo));
        check("done_wb_rd", 32'(wb_rd), 32'(rd));
        if (is_load && !tmo) check("done_wb_data", wb_data, exp_data);
        check("done_err_timeout", 32'(err_timeout), 32'(tmo));
        check("done_err_misalign", 32'(err_misalign), 32'd0);
        check("done_mem_req", 32'(mem_req), 32'd0);
        check("done_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        mem_ready = 1'b0;
        check("post_stall", 32'(stall), 32'd0);
        check("post_wb_valid", 32'(wb_valid), 32'd0);
        check("post_err_timeout", 32'(err_timeout), 32'd0);
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] addr;
        int          k;
        int          r;

        // Asynchronous reset, released away from the active edge.
        #1 reset_n = 1'b0;
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_errs", 32'({err_misalign, err_timeout}), 32'd0);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios.
        run_op(ADDIU, 32'h0000_1234, 32'h0, 5'd5, 1, 32'h0);
        run_op(SB, 32'h0000_100A, 32'h0000_00AB, 5'd7, 3, 32'h0);
        run_op(LBU, 32'h0000_2003, 32'h0, 5'd9, 1, 32'h9F00_0000);
        run_op(LW, 32'h0000_3002, 32'h0, 5'd10, 1, 32'h0);
        run_op(LW, 32'h0000_4000, 32'h0, 5'd11, MAX_WAIT + 1, 32'h0);
        run_op(ADDIU, 32'hDEAD_BEEF, 32'h0, 5'd12, 1, 32'h0);
        run_op(LW, 32'h0000_5004, 32'h0, 5'd13, MAX_WAIT, 32'hCAFE_F00D);

        // Reset in the middle of an access abandons it without a write-back.
        in_valid      = 1'b1;
        in_opcode     = LW;
        in_alu_result = 32'h0000_6000;
        in_rd         = 5'd14;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_wb_valid", 32'(wb_valid), 32'd0);
        check("postrst_stall", 32'(stall), 32'd0);
        run_op(SW, 32'h0000_7000, 32'h1234_5678, 5'd15, 2, 32'h0);
        run_op(LW, 32'h0000_7000, 32'h0, 5'd16, 1, 32'h1234_5678);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: op = LW;
                1: op = SW;
                2: op = LBU;
                3: op = SB;
                default: op = 6'($urandom_range(0, 31));
            endcase
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            if (r < 7)       k = $urandom_range(1, 5);
            else if (r == 7) k = MAX_WAIT;
            else if (r == 8) k = MAX_WAIT + 1;
            else             k = 1;
            run_op(op, addr, $urandom, 5'($urandom), k, $urandom);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the full pipelined processor: consumes the EX/MEM result (ALU address or arithmetic result), performs LW/SW/LBU/SB accesses on a single-outstanding req/ready data-memory port, and produces the registered write-back value. Stalls the upstream pipeline while a memory access is in flight, and flags misaligned word accesses and memory timeouts.

## Interface
Parameters:
- MAX_WAIT, 16, cycles mem_req may stay unacknowledged before a bus error (≥2)
- WAIT_W, $clog2(MAX_WAIT+1), width of wait counter

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  EX/MEM slot holds an instruction
- in_opcode  input  6  primary opcode (LW 100011, SW 101011, LBU 100100, SB 101000; others are non-memory)
- in_alu_result  input  32  ALU output: effective address for memory ops, result otherwise
- in_store_data  input  32  rt value for SW/SB
- in_rd  input  5  destination register
- stall  output  1  upstream must hold EX/MEM; in_valid ignored while high
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  1 = store
- mem_addr  output  32  word address ({addr[31:2],2'b00})
- mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  output  32  store data, replicated per lane
- mem_ready  input  1  memory accepts/completes request this cycle
- mem_rdata  input  32  load data, valid when mem_ready && !mem_we
- wb_valid  output  1  write-back slot valid (one-cycle pulse per instruction)
- wb_we  output  1  register write required (0 for SW/SB and errored ops)
- wb_rd  output  5  destination register
- wb_data  output  32  write-back value
- err_misalign  output  1  one-cycle pulse: LW/SW with addr[1:0]≠0
- err_timeout  output  1  one-cycle pulse: MAX_WAIT exceeded

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, in_valid, non-memory opcode: register wb_data=in_alu_result, wb_rd, wb_we=1, wb_valid=1 next cycle; stay IDLE.
- IDLE, in_valid, LW/SW misaligned: no memory access; next cycle wb_valid=1, wb_we=0, err_misalign=1; stay IDLE.
- IDLE, in_valid, aligned memory op: latch address/data/opcode/rd, go ACCESS.
- ACCESS: mem_req=1 with stable mem_we/mem_addr/mem_be/mem_wdata; wait counter increments each cycle.
  - mem_ready: capture read data, go DONE.
  - counter reaches MAX_WAIT without mem_ready: drop mem_req, go DONE with error.
- DONE: wb_valid=1 for one cycle; go IDLE.
  - LW: wb_data=mem_rdata, wb_we=1. LBU: wb_data={24'b0, rdata byte lane addr[1:0]}, wb_we=1.
  - SW/SB: wb_we=0. Timeout: wb_we=0, err_timeout=1.
- Byte lanes: SW be=4'b1111, wdata=store_data; SB be=4'b0001<<addr[1:0], wdata={4{store_data[7:0]}}. LW be=4'b1111; LBU be=4'b1111 (full word read, lane selected internally).
- stall = (state≠IDLE). Exactly one access outstanding.
- in_valid=0: wb_valid=0 next cycle; FSM unchanged.

## Timing
- Reset (async assert, sync deassert usage): state=IDLE, all outputs 0, counter 0; reset during ACCESS drops mem_req immediately, transaction abandoned, no wb pulse.
- Non-memory/misaligned latency: 1 cycle accept→wb_valid, no stall.
- Memory op: accept at cycle T; mem_req high T+1..T+k where mem_ready first sampled high at T+k; wb_valid at T+k+1; stall high T+1..T+k+1; next instruction accepted at T+k+2 rising edge (stall low in cycle T+k+2).
- Zero-wait memory (mem_ready high at T+1): wb_valid at T+2, stall 2 cycles.
- mem_ready while mem_req=0: ignored.
- Timeout: mem_req high exactly MAX_WAIT cycles, err_timeout and wb_valid at following cycle.
- mem_ready on the same cycle counter hits MAX_WAIT: success wins, no error.

## Structure
- Shared package (processor-wide): opcode constants OP_LW, OP_SW, OP_LBU, OP_SB; typedef enum for FSM state; byte-enable helper function be_for(opcode, addr_lo).
- Optional sub-module load_align: combinational lane select/zero-extend of mem_rdata for LBU/LW.

## Test plan
- ADDIU result 0x0000_1234, rd=5 → wb_valid next cycle, wb_data=0x1234, wb_we=1, stall never high, mem_req never high.
- SB addr 0x100A, data 0xAB, mem_ready after 3 cycles → mem_addr 0x1008, mem_be 0100, mem_wdata 0xABABABAB, wb_we=0, stall 4 cycles.
- LBU addr 0x2003, mem_rdata 0x9F00_0000, zero-wait → wb_data 0x0000_009F, wb_valid at T+2.
- LW addr 0x3002 → err_misalign pulse, wb_we=0, no mem_req.
- LW with mem_ready never asserted, MAX_WAIT=16 → mem_req high 16 cycles, err_timeout pulse, stall clears, next op accepted.
- reset_n asserted mid-ACCESS → mem_req, stall, wb_valid drop to 0 asynchronously; after release, back-to-back SW/LW complete normally.
